mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory port between the IF stage (instruction
//  fetch) and the MEM stage (load/store issued under ram_we / ram_ext_op
//  control). One transaction is outstanding at a time. Each requester gets a
//  grant pulse, and later a completion pulse with read data.
//  Sits between the pipeline stages and the bus wrapper in mycpu_top.
// PARAMETERS
//  AW            32  address width
//  DW            32  data width
//  DM_BURST_MAX  4   max consecutive MEM grants while IF is waiting
//  TIMEOUT_CYC   64  ack watchdog limit (used only with ARB_TIMEOUT_EN)
// PORTS
//  cpu_clk     in   1   clock, rising edge
//  cpu_rstn    in   1   asynchronous active-low reset
//  if_req      in   1   fetch request, held until if_gnt
//  if_addr     in   AW  fetch address
//  if_gnt      out  1   fetch accepted (combinational, this cycle)
//  if_rvalid   out  1   1-cycle pulse; if_rdata valid
//  if_rdata    out  DW  fetched instruction word
//  dm_req      in   1   load/store request, held until dm_gnt
//  dm_we       in   4   byte write enables; 4'b0000 = load
//  dm_addr     in   AW  data address
//  dm_wdata    in   DW  store data
//  dm_gnt      out  1   data access accepted (combinational, this cycle)
//  dm_rvalid   out  1   1-cycle pulse; load data valid or store done
//  dm_rdata    out  DW  load data (raw word; the MEM stage extends it)
//  bus_req     out  1   bus request, held until bus_ack
//  bus_we      out  4   registered copy of the granted dm_we (0 for fetch)
//  bus_addr    out  AW  registered address
//  bus_wdata   out  DW  registered store data
//  bus_ack     in   1   bus completes in this cycle; bus_rdata valid
//  bus_rdata   in   DW  bus read data
//  bus_err     out  1   timeout pulse (always 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - FSM states: IDLE, IF_WAIT, DM_WAIT.
//  - Reset: state=IDLE. All outputs are 0, including rdata, bus_* and streak.
//  - Grants are issued only in IDLE; at most one gnt per cycle.
//    - Pick MEM when dm_req=1 and NOT (if_req=1 and streak==DM_BURST_MAX).
//    - Otherwise pick IF when if_req=1.
//  - On the grant edge:
//    - Latch addr, we and wdata into the bus_* registers.
//    - Move to IF_WAIT or DM_WAIT.
//    - bus_req=1 from the next cycle.
//  - WAIT state with bus_ack=1:
//    - bus_req drops on the next edge.
//    - The owner's rdata is loaded from bus_rdata.
//    - The owner's rvalid=1 for exactly the next cycle.
//    - State returns to IDLE.
//  - Minimum latency: gnt at cycle T, bus_req at T+1, ack at T+1, rvalid at
//    T+2. Back-to-back throughput is one access per 2 cycles.
//  - bus_ack while in IDLE is ignored.
//  - bus_* outputs stay stable while bus_req=1.
//  - streak counter (saturating, 0..DM_BURST_MAX):
//    - +1 on a MEM grant while if_req=1.
//    - Cleared on an IF grant, or on any cycle with if_req=0.
//  - dm_rdata and if_rdata hold their values until the next completion for
//    the same requester.
//  - Async reset during a WAIT state:
//    - The transaction is abandoned. No rvalid is generated.
//    - The FSM restarts in IDLE.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined:
//    - A cycle counter runs in the WAIT states and is cleared on grant.
//    - If it reaches TIMEOUT_CYC with no ack:
//      - bus_req drops and bus_err pulses for 1 cycle.
//      - The owner's rvalid pulses with rdata=32'hDEADBEEF.
//      - State returns to IDLE.
//  - ARB_TIMEOUT_EN undefined:
//    - No counter. A WAIT state lasts until bus_ack.
//    - bus_err is tied to 0.
// TESTING
//  1. Reset mid-DM_WAIT -> next cycle: bus_req=0, no rvalid, state IDLE;
//     all outputs 0.
//  2. if_req=1, addr=0x1C000000; ack at T+1 with rdata=0x02800421 ->
//     if_gnt@T, bus_req@T+1, if_rvalid=1 and if_rdata=0x02800421 @T+2.
//  3. if_req and dm_req in the same cycle (load 0x100, ack after 3 cycles) ->
//     dm_gnt first, dm_rvalid; then if_gnt in the following IDLE cycle.
//  4. dm_req held for 6 transactions with if_req held high -> 4 dm_gnt,
//     then 1 if_gnt, then dm_gnt again.
//  5. Store dm_we=4'b0011, addr=0x200, wdata=0xABCD1234 -> bus_we=0011 and
//     bus_wdata stable until ack; dm_rvalid one cycle after ack.
//  6. With ARB_TIMEOUT_EN and TIMEOUT_CYC=64, bus_ack never asserted ->
//     bus_err=1 and dm_rvalid=1 with dm_rdata=0xDEADBEEF after 64 cycles;
//     without the macro, still waiting at cycle 200.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external memory port between instruction fetch (IF) and the
// load/store stage (MEM). Only one bus transaction is in flight at a time.
// Grants are combinational and are issued only from IDLE. On the grant edge
// the request is copied into the bus_* registers. A completion pulse
// (*_rvalid) with the read word follows one cycle after bus_ack.
//
// MEM normally has priority. To keep fetch from starving, a streak counter
// tracks consecutive MEM grants taken while IF is waiting. Once it reaches
// DM_BURST_MAX, IF is served next.
//
// Build option:
//   ARB_TIMEOUT_EN - adds an ack watchdog. After TIMEOUT_CYC wait cycles
//                    without bus_ack, the transaction is dropped. bus_err
//                    pulses and the owner gets rvalid with 32'hDEADBEEF.
//                    Without the macro, bus_err is tied low and a wait lasts
//                    until bus_ack.
//
// Ports:
//   cpu_clk, cpu_rstn            clock (rising edge), async active-low reset
//   if_req/if_addr               fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata    fetch grant, completion pulse, read word
//   dm_req/dm_we/dm_addr/dm_wdata   load/store request (dm_we==0 -> load)
//   dm_gnt/dm_rvalid/dm_rdata    data grant, completion pulse, read word
//   bus_req/bus_we/bus_addr/bus_wdata   registered bus request
//   bus_ack/bus_rdata            bus completion and read data
//   bus_err                      watchdog timeout pulse
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int DM_BURST_MAX = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic          cpu_clk,
    input  logic          cpu_rstn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic [3:0]    dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          bus_req,
    output logic [3:0]    bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata,
    output logic          bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } state_e;

    localparam int            SW         = $clog2(DM_BURST_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DM_BURST_MAX);

    state_e          state_q,     state_d;
    logic [SW-1:0]   streak_q,    streak_d;
    logic            bus_req_q,   bus_req_d;
    logic [3:0]      bus_we_q,    bus_we_d;
    logic [AW-1:0]   bus_addr_q,  bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            dm_rvalid_q, dm_rvalid_d;
    logic [DW-1:0]   if_rdata_q,  if_rdata_d;
    logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;
    logic            done;
    logic [DW-1:0]   done_data;

`ifdef ARB_TIMEOUT_EN
    localparam int            TW           = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST      = TW'(TIMEOUT_CYC - 1);
    localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF);

    logic [TW-1:0]   to_cnt_q,    to_cnt_d;
    logic            bus_err_q,   bus_err_d;
`endif

    // NOTE: every variable driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        done        = 1'b0;
        done_data   = bus_rdata;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        bus_err_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                // MEM wins unless IF has already waited out a full burst.
                if (dm_req && !(if_req && streak_q == STREAK_MAX)) begin
                    dm_gnt      = 1'b1;
                    state_d     = DM_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                end else if (if_req) begin
                    if_gnt      = 1'b1;
                    state_d     = IF_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 4'b0000;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                end
`ifdef ARB_TIMEOUT_EN
                if (dm_gnt || if_gnt) begin
                    to_cnt_d = '0;
                end
`endif
            end
            IF_WAIT, DM_WAIT: begin
                if (bus_ack) begin
                    done = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    done      = 1'b1;
                    done_data = TIMEOUT_DATA;
                    bus_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
            if (state_q == IF_WAIT) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = done_data;
            end else begin
                dm_rvalid_d = 1'b1;
                dm_rdata_d  = done_data;
            end
        end

        // The streak only matters while IF is actually waiting.
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (dm_gnt && streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Each table row is one clock cycle.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled 4 ns
// after the edge, before the falling edge. Hand-written sequences cover
// burst fairness, the no-ack case and reset during a wait.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TIMEOUT_CYC = 64;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .AW          (32),
        .DW          (32),
        .DM_BURST_MAX(4),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .bus_err  (bus_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [3:0]  we;
        logic [31:0] da;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] rd;
        logic        e_ig;
        logic        e_dg;
        logic        e_br;
        logic        e_iv;
        logic        e_dv;
        logic [3:0]  e_we;
        logic [31:0] e_ba;
        logic [31:0] e_wd;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    logic exp_dm [6];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr,
        input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd,
        input logic ack, input logic [31:0] rd,
        input logic e_ig, input logic e_dg, input logic e_br,
        input logic e_iv, input logic e_dv, input logic [3:0] e_we,
        input logic [31:0] e_ba, input logic [31:0] e_wd,
        input logic [31:0] e_ird, input logic [31:0] e_drd);
        vec_t v;
        v.ir = ir;  v.ia = ia;  v.dr = dr;  v.we = we;  v.da = da;
        v.wd = wd;  v.ack = ack;  v.rd = rd;
        v.e_ig = e_ig;  v.e_dg = e_dg;  v.e_br = e_br;
        v.e_iv = e_iv;  v.e_dv = e_dv;  v.e_we = e_we;
        v.e_ba = e_ba;  v.e_wd = e_wd;  v.e_ird = e_ird;  v.e_drd = e_drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        if_req    = v.ir;
        if_addr   = v.ia;
        dm_req    = v.dr;
        dm_we     = v.we;
        dm_addr   = v.da;
        dm_wdata  = v.wd;
        bus_ack   = v.ack;
        bus_rdata = v.rd;
    endtask

    task automatic check_row(input int r, input vec_t v);
        check($sformatf("row%0d if_gnt", r),    32'(if_gnt),    32'(v.e_ig));
        check($sformatf("row%0d dm_gnt", r),    32'(dm_gnt),    32'(v.e_dg));
        check($sformatf("row%0d bus_req", r),   32'(bus_req),   32'(v.e_br));
        check($sformatf("row%0d if_rvalid", r), 32'(if_rvalid), 32'(v.e_iv));
        check($sformatf("row%0d dm_rvalid", r), 32'(dm_rvalid), 32'(v.e_dv));
        check($sformatf("row%0d bus_we", r),    32'(bus_we),    32'(v.e_we));
        check($sformatf("row%0d bus_addr", r),  bus_addr,       v.e_ba);
        check($sformatf("row%0d bus_wdata", r), bus_wdata,      v.e_wd);
        check($sformatf("row%0d if_rdata", r),  if_rdata,       v.e_ird);
        check($sformatf("row%0d dm_rdata", r),  dm_rdata,       v.e_drd);
        check($sformatf("row%0d bus_err", r),   32'(bus_err),   32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " if_gnt"},    32'(if_gnt),    32'd0);
        check({tag, " dm_gnt"},    32'(dm_gnt),    32'd0);
        check({tag, " bus_req"},   32'(bus_req),   32'd0);
        check({tag, " bus_we"},    32'(bus_we),    32'd0);
        check({tag, " bus_addr"},  bus_addr,       32'd0);
        check({tag, " bus_wdata"}, bus_wdata,      32'd0);
        check({tag, " if_rvalid"}, 32'(if_rvalid), 32'd0);
        check({tag, " dm_rvalid"}, 32'(dm_rvalid), 32'd0);
        check({tag, " if_rdata"},  if_rdata,       32'd0);
        check({tag, " dm_rdata"},  dm_rdata,       32'd0);
        check({tag, " bus_err"},   32'(bus_err),   32'd0);
    endtask

    // Completion of burst slot j: the owner's rvalid and data, the other idle.
    task automatic check_done(input int j);
        if (exp_dm[j]) begin
            check($sformatf("burst%0d dm_rvalid", j), 32'(dm_rvalid), 32'd1);
            check($sformatf("burst%0d dm_rdata", j),  dm_rdata, 32'h1000 + 32'(j));
            check($sformatf("burst%0d if_rvalid", j), 32'(if_rvalid), 32'd0);
        end else begin
            check($sformatf("burst%0d if_rvalid", j), 32'(if_rvalid), 32'd1);
            check($sformatf("burst%0d if_rdata", j),  if_rdata, 32'h1000 + 32'(j));
            check($sformatf("burst%0d dm_rvalid", j), 32'(dm_rvalid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Cycle-by-cycle table: single fetch, store with noisy inputs while
        // waiting, simultaneous requests, ack ignored in IDLE.
        vecs[0]  = mk(1'b1, 32'h1C000000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1]  = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h02800421,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h1C000000, 32'h0, 32'h0, 32'h0);
        vecs[2]  = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h1C000000, 32'h0, 32'h02800421, 32'h0);
        vecs[3]  = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h1C000000, 32'h0, 32'h02800421, 32'h0);
        vecs[4]  = mk(1'b0, 32'h0, 1'b1, 4'h3, 32'h200, 32'hABCD1234, 1'b0, 32'h0,
                      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h1C000000, 32'h0, 32'h02800421, 32'h0);
        vecs[5]  = mk(1'b0, 32'h0, 1'b0, 4'hF, 32'hFFC, 32'h5A5A5A5A, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 32'h200, 32'hABCD1234, 32'h02800421, 32'h0);
        vecs[6]  = mk(1'b0, 32'h0, 1'b0, 4'hF, 32'hFFC, 32'h5A5A5A5A, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 32'h200, 32'hABCD1234, 32'h02800421, 32'h0);
        vecs[7]  = mk(1'b0, 32'h0, 1'b0, 4'hF, 32'hFFC, 32'h5A5A5A5A, 1'b1, 32'h0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 32'h200, 32'hABCD1234, 32'h02800421, 32'h0);
        vecs[8]  = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 32'h200, 32'hABCD1234, 32'h02800421, 32'h0);
        vecs[9]  = mk(1'b1, 32'h1C000004, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 32'h200, 32'hABCD1234, 32'h02800421, 32'h0);
        vecs[10] = mk(1'b1, 32'h1C000004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h02800421, 32'h0);
        vecs[11] = mk(1'b1, 32'h1C000004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h02800421, 32'h0);
        vecs[12] = mk(1'b1, 32'h1C000004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h02800421, 32'h0);
        vecs[13] = mk(1'b1, 32'h1C000004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 32'h02800421, 32'hCAFEF00D);
        vecs[14] = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h11112222,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h1C000004, 32'h0, 32'h02800421, 32'hCAFEF00D);
        vecs[15] = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h99999999,
                      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h1C000004, 32'h0, 32'h11112222, 32'hCAFEF00D);
        vecs[16] = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h1C000004, 32'h0, 32'h11112222, 32'hCAFEF00D);

        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        if_req = 1'b0;  if_addr = '0;  dm_req = 1'b0;  dm_we = '0;
        dm_addr = '0;  dm_wdata = '0;  bus_ack = 1'b0;  bus_rdata = '0;
        cpu_rstn = 1'b1;
        #3 cpu_rstn = 1'b0;
        #10;
        check_all_zero("reset");
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        tick();

        // ---------------- table ----------------
        for (int r = 0; r < NVEC; r++) begin
            drive(vecs[r]);
            #3;
            check_row(r, vecs[r]);
            tick();
        end

        // ---------------- MEM burst limit with IF waiting ----------------
        if_req = 1'b1;  dm_req = 1'b1;  dm_we = 4'h0;  dm_wdata = '0;
        for (int i = 0; i < 6; i++) begin
            if_addr = 32'h1C001000 + 32'(i * 4);
            dm_addr = 32'h00002000 + 32'(i * 4);
            bus_ack = 1'b0;
            #3;
            if (i > 0) check_done(i - 1);
            check($sformatf("burst%0d dm_gnt", i), 32'(dm_gnt), 32'(exp_dm[i]));
            check($sformatf("burst%0d if_gnt", i), 32'(if_gnt), 32'(!exp_dm[i]));
            tick();
            bus_ack = 1'b1;
            bus_rdata = 32'h1000 + 32'(i);
            #3;
            check($sformatf("burst%0d bus_req", i), 32'(bus_req), 32'd1);
            check($sformatf("burst%0d addr", i), bus_addr,
                  exp_dm[i] ? 32'h00002000 + 32'(i * 4) : 32'h1C001000 + 32'(i * 4));
            tick();
        end
        if_req = 1'b0;  dm_req = 1'b0;  bus_ack = 1'b0;
        #3;
        check_done(5);
        tick();

        // ---------------- load with no ack ----------------
        dm_req = 1'b1;  dm_we = 4'h0;  dm_addr = 32'h400;
        #3;
        check("noack dm_gnt", 32'(dm_gnt), 32'd1);
        tick();
        dm_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        begin
            int k;
            k = 0;
            for (int c = 1; c <= 300; c++) begin
                #3;
                if (bus_err === 1'b1) begin
                    k = c;
                    break;
                end
                tick();
            end
            check("timeout cycle", 32'(k), 32'(TIMEOUT_CYC + 1));
            check("timeout dm_rvalid", 32'(dm_rvalid), 32'd1);
            check("timeout dm_rdata", dm_rdata, 32'hDEADBEEF);
            check("timeout bus_req", 32'(bus_req), 32'd0);
            tick();
            #3;
            check("timeout bus_err pulse", 32'(bus_err), 32'd0);
            check("timeout rvalid pulse", 32'(dm_rvalid), 32'd0);
            tick();
        end
`else
        begin
            int events;
            events = 0;
            for (int c = 1; c <= 200; c++) begin
                #3;
                if (dm_rvalid || bus_err) events++;
                if (c == 200) begin
                    check("noack bus_req@200", 32'(bus_req), 32'd1);
                    check("noack events", 32'(events), 32'd0);
                end
                tick();
            end
            bus_ack = 1'b1;
            bus_rdata = 32'h00000077;
            tick();
            bus_ack = 1'b0;
            #3;
            check("late ack dm_rvalid", 32'(dm_rvalid), 32'd1);
            check("late ack dm_rdata", dm_rdata, 32'h00000077);
            tick();
        end
`endif

        // ---------------- reset in the middle of DM_WAIT ----------------
        dm_req = 1'b1;  dm_we = 4'h1;  dm_addr = 32'h300;  dm_wdata = 32'h12345678;
        #3;
        check("rst dm_gnt", 32'(dm_gnt), 32'd1);
        tick();
        dm_req = 1'b0;
        #1;
        check("rst bus_req before", 32'(bus_req), 32'd1);
        cpu_rstn = 1'b0;
        #1;
        check_all_zero("midwait reset");
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        tick();
        #3;
        check("after rst bus_req", 32'(bus_req), 32'd0);
        check("after rst dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("after rst if_rvalid", 32'(if_rvalid), 32'd0);
        tick();
        bus_ack = 1'b0;
        #3;
        check("after rst dm_rvalid 2", 32'(dm_rvalid), 32'd0);
        check("after rst dm_rdata", dm_rdata, 32'd0);
        check("after rst bus_req 2", 32'(bus_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
